joybus_tx: RTL
==============

# joybus_tx

Host-side Joybus transmitter. It serialises a 1–3 byte console command (for example 0x00 info, 0x01 N64 poll, or 0x400300 GameCube poll) onto the open-drain controller line, appends the console stop bit, and releases the line. In the same cycle it releases the line, it pulses `rx_start` so the downstream Joybus receiver starts capturing the controller's reply. Bit timing uses the same 25 MHz / 100-cycles-per-bit base as the receive path.

## Interface
Parameters:
- `CYC_US`, default 25: clock cycles per microsecond. Bit period is `4*CYC_US`; a short low phase is `CYC_US`; a long low phase is `3*CYC_US`.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_start`  in  1  single-cycle request; sampled only in IDLE.
- `tx_len`  in  2  number of command bytes (0–3); 0 sends the stop bit only.
- `tx_data`  in  24  command bytes, left-aligned, sent MSB first (`tx_data[23]` goes out first).
- `JB_TX_low`  out  1  registered; 1 = pull the line low, 0 = release (pad pull-up holds it high).
- `tx_busy`  out  1  high from the cycle after `tx_start` is accepted until return to IDLE.
- `tx_done`  out  1  one-cycle pulse when the stop bit finishes.
- `rx_start`  out  1  one-cycle pulse, same cycle as `tx_done`; connects to the receiver's start input.

## Operation
- Latched on accept:
  - `tx_data` goes into a 24-bit shift register.
  - `tx_len*8` goes into the bit counter (6 bits; values 0, 8, 16 or 24).
  - The phase counter is cleared. Its width is `$clog2(4*CYC_US)`.
- States:
  - IDLE: outputs 0. On `tx_start`, latch as above; go to LOW if bits remain, otherwise go to STOP_LOW.
  - LOW: `JB_TX_low`=1. The low time is `3*CYC_US` cycles if `shift[23]`=0, or `CYC_US` cycles if `shift[23]`=1. Then go to HIGH; the phase counter keeps running.
  - HIGH: `JB_TX_low`=0 until the phase counter reaches `4*CYC_US-1`. At that point:
    - shift left by 1;
    - decrement the bit counter;
    - clear the phase counter;
    - go to LOW if the bit counter is nonzero after the decrement, otherwise go to STOP_LOW.
  - STOP_LOW: `JB_TX_low`=1 for `CYC_US` cycles. Then:
    - `JB_TX_low`=0;
    - pulse `tx_done` and `rx_start`;
    - go to IDLE.
- The block does not drive the 2 µs high tail of the console stop bit. The receiver owns the line from the release onward.
- `tx_start` while `tx_busy`=1 is ignored. It is not queued and does not disturb the transfer in progress.
- `tx_data` and `tx_len` are don't-care except in the accept cycle.

## Timing
- Reset value of all outputs is 0 (line released). The state returns to IDLE and all counters clear.
- Accept cycle:
  - `tx_start` is sampled at edge k.
  - `JB_TX_low` and `tx_busy` are 1 from edge k onward (registered, one-edge latency).
  - If `tx_len`=0, `JB_TX_low` is still 1 from edge k, because STOP_LOW begins immediately.
- Each data bit takes exactly `4*CYC_US` cycles:
  - bit 0: 75 low then 25 high;
  - bit 1: 25 low then 75 high.
- Bits follow back-to-back with no gap. The falling edge of bit n+1 is at the edge where bit n's high phase ends.
- For N = `tx_len*8` data bits, the stop low phase spans edges k+100N to k+100N+24.
- At edge k+100N+25:
  - `JB_TX_low` falls to 0;
  - `tx_done` and `rx_start` pulse high for exactly one cycle;
  - `tx_busy` goes low.
- A new `tx_start` is accepted at edge k+100N+26 at the earliest.
- `rst` mid-transfer: at the next edge `JB_TX_low`=0, all pulses are 0, and the state is IDLE. A partial frame is abandoned with no `rx_start`.
- `rst` and `tx_start` in the same cycle: reset wins and nothing is accepted.

## Test plan
- `tx_len`=1, `tx_data`=0x000000 (info): eight bits of 75 low / 25 high, then 25 cycles low; `rx_start`/`tx_done` at k+825; total `JB_TX_low` high cycles = 625.
- `tx_len`=1, `tx_data`=0x010000 (N64 poll): bits 0–6 are 75/25 and bit 7 is 25/75; stop bit; `rx_start` at k+825.
- `tx_len`=3, `tx_data`=0x400300 (GC poll): decode the line back to 0x400300 MSB-first; `rx_start` at k+2425; `tx_busy` high for k..k+2424.
- `tx_len`=0: `JB_TX_low` high for edges k..k+24; `rx_start` at k+25; no data bits sent.
- `tx_start` re-pulsed at k+300 during a 3-byte frame: the frame is unchanged and exactly one `rx_start` occurs. Then `tx_start` at k+2426 is accepted.
- `rst` asserted at k+410 during a 3-byte frame: `JB_TX_low`=0 at the next edge, no `tx_done`/`rx_start` ever, and a fresh 1-byte frame afterwards times correctly.

Source files
------------

// File: rtl/joybus_tx.sv
// joybus_tx -- host-side Joybus command transmitter.
//
// Serialises a 1-3 byte console command MSB first onto the open-drain
// controller line, appends the short console stop-bit low phase, then
// releases the line. In the release cycle it pulses rx_start so the Joybus
// receiver takes over the line and captures the controller's reply.
//
// Bit encoding (period 4*CYC_US clocks):
//   '0' -> 3*CYC_US low, CYC_US high
//   '1' -> CYC_US low, 3*CYC_US high
// The stop bit is CYC_US low. Its 2 us high tail is left to the pull-up and
// the receiver.
//
// Ports:
//   clk        in   system clock (single domain)
//   rst        in   synchronous active-high reset
//   tx_start   in   one-cycle request, sampled only while idle
//   tx_len     in   command length in bytes (0-3); 0 sends the stop bit only
//   tx_data    in   command bytes, left-aligned, tx_data[23] sent first
//   JB_TX_low  out  registered; 1 = pull the line low, 0 = release
//   tx_busy    out  high from the accept edge until the return to idle
//   tx_done    out  one-cycle pulse when the stop-bit low phase ends
//   rx_start   out  one-cycle pulse, coincident with tx_done
module joybus_tx #(
  parameter int CYC_US = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [1:0]  tx_len,
  input  logic [23:0] tx_data,
  output logic        JB_TX_low,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        rx_start
);

  localparam int BIT_CYC = 4 * CYC_US;
  localparam int PH_W    = $clog2(BIT_CYC);

  // Phase-counter values at which each phase ends (last cycle of the phase).
  localparam logic [PH_W-1:0] PH_ZERO      = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ONE       = PH_W'(1);
  localparam logic [PH_W-1:0] PH_SHORT_END = PH_W'(CYC_US - 1);
  localparam logic [PH_W-1:0] PH_LONG_END  = PH_W'(3 * CYC_US - 1);
  localparam logic [PH_W-1:0] PH_BIT_END   = PH_W'(BIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2,
    STOP_LOW = 2'd3
  } state_t;

  state_t            state_r;
  logic [23:0]       shift_r;
  logic [5:0]        bit_cnt_r;
  logic [PH_W-1:0]   phase_r;
  logic [PH_W-1:0]   low_end_s;

  // A '1' bit has the short low phase, a '0' bit the long one.
  assign low_end_s = shift_r[23] ? PH_SHORT_END : PH_LONG_END;

  // Transmit sequencer with registered line drive and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= 24'd0;
      bit_cnt_r <= 6'd0;
      phase_r   <= PH_ZERO;
      JB_TX_low <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      rx_start  <= 1'b0;
    end else begin
      // Pulses are high for one cycle only; the STOP_LOW exit re-asserts them.
      tx_done  <= 1'b0;
      rx_start <= 1'b0;

      case (state_r)
        IDLE: begin
          if (tx_start) begin
            shift_r   <= tx_data;
            bit_cnt_r <= {1'b0, tx_len, 3'b000};
            phase_r   <= PH_ZERO;
            // Both LOW and STOP_LOW start with the line pulled low, so the
            // drive goes active on the accept edge itself.
            JB_TX_low <= 1'b1;
            tx_busy   <= 1'b1;
            if (tx_len != 2'd0) begin
              state_r <= LOW;
            end else begin
              state_r <= STOP_LOW;
            end
          end else begin
            JB_TX_low <= 1'b0;
            tx_busy   <= 1'b0;
          end
        end

        LOW: begin
          // The phase counter spans the whole bit, so it keeps counting
          // through the low-to-high transition.
          phase_r <= phase_r + PH_ONE;
          if (phase_r == low_end_s) begin
            JB_TX_low <= 1'b0;
            state_r   <= HIGH;
          end else begin
            JB_TX_low <= 1'b1;
          end
        end

        HIGH: begin
          if (phase_r == PH_BIT_END) begin
            shift_r   <= {shift_r[22:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 6'd1;
            phase_r   <= PH_ZERO;
            // Next bit (or the stop bit) begins low with no gap.
            JB_TX_low <= 1'b1;
            if (bit_cnt_r == 6'd1) begin
              state_r <= STOP_LOW;
            end else begin
              state_r <= LOW;
            end
          end else begin
            phase_r   <= phase_r + PH_ONE;
            JB_TX_low <= 1'b0;
          end
        end

        STOP_LOW: begin
          if (phase_r == PH_SHORT_END) begin
            // Release the line and hand it to the receiver in the same cycle.
            phase_r   <= PH_ZERO;
            JB_TX_low <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
            rx_start  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            phase_r   <= phase_r + PH_ONE;
            JB_TX_low <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          phase_r   <= PH_ZERO;
          JB_TX_low <= 1'b0;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
